// File: rtl/register_file_pkg.sv
// regfile_pkg: shared constants and types for the register file.
// Build option: REGFILE_ZERO_REG_EN makes register 0 read as zero and ignore writes.
package regfile_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int SEL_WIDTH = 3;
  localparam int NUM_REGS = 2 ** SEL_WIDTH;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [SEL_WIDTH-1:0] sel_t;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif
endpackage

// File: rtl/register_file_if.sv
// register_file_if: write port and two read ports of the register file.
// Signals: REG_WE (active-low write enable), DIn, REG_Dst, REG_Src1, REG_Src2, SRC1, SRC2.
// Modports: master drives the selects, write enable and write data; slave drives SRC1 and SRC2.
interface register_file_if
  import regfile_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH,
  parameter int SelectSize = SEL_WIDTH
);
  logic REG_WE;
  logic [DataWidth-1:0] DIn;
  logic [SelectSize-1:0] REG_Dst;
  logic [SelectSize-1:0] REG_Src1;
  logic [SelectSize-1:0] REG_Src2;
  logic [DataWidth-1:0] SRC1;
  logic [DataWidth-1:0] SRC2;
  modport master (output REG_WE, DIn, REG_Dst, REG_Src1, REG_Src2, input SRC1, SRC2);
  modport slave (input REG_WE, DIn, REG_Dst, REG_Src1, REG_Src2, output SRC1, SRC2);
endinterface

// File: rtl/register_file_cell.sv
// register_cell: one falling-edge data register with synchronous clear and active-high load.
// Ports: Clk, Reset (sync, active-high, wins over load), load, d (data in), q (data out).
module register_cell #(
  parameter int Width = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);
  always_ff @(negedge Clk)
    q <= Reset ? '0 : load ? d : q;
endmodule

// File: rtl/register_file.sv
// register_file: 2**SelectSize x DataWidth register file, one falling-edge write port, two combinational read ports.
// Ports: Clk, Reset (sync, active-high), bus (register_file_if.slave).
// Build option: REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module register_file
  import regfile_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH,
  parameter int SelectSize = SEL_WIDTH
) (
  input logic Clk,
  input logic Reset,
  register_file_if.slave bus
);
  localparam int Depth = 2 ** SelectSize;
  logic [DataWidth-1:0] q [Depth];
  logic [Depth-1:0] load;
  for (genvar i = 0; i < Depth; i++) begin : g_reg
    assign load[i] = !bus.REG_WE && bus.REG_Dst == SelectSize'(i) && !(ZERO_REG_EN && i == 0);
    register_cell #(.Width(DataWidth)) u_cell (
      .Clk  (Clk),
      .Reset(Reset),
      .load (load[i]),
      .d    (bus.DIn),
      .q    (q[i])
    );
  end
  assign bus.SRC1 = (ZERO_REG_EN && bus.REG_Src1 == '0) ? '0 : q[bus.REG_Src1];
  assign bus.SRC2 = (ZERO_REG_EN && bus.REG_Src2 == '0) ? '0 : q[bus.REG_Src2];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vector table, read-during-write sequences and randomized model check for register_file.
module tb_register_file;
  import regfile_pkg::*;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit Z = 1'b1;
`else
  localparam bit Z = 1'b0;
`endif
  logic Clk = 1'b0;
  logic Reset;
  int errors = 0;
  int checks = 0;
  data_t model [NUM_REGS];
  register_file_if #(.DataWidth(DATA_WIDTH), .SelectSize(SEL_WIDTH)) bus ();
  register_file dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #10 Clk = ~Clk;
  typedef struct {
    logic  rst;
    logic  we;
    sel_t  dst;
    data_t din;
    sel_t  s1;
    sel_t  s2;
    data_t e1;
    data_t e2;
  } vec_t;
  vec_t tbl [9];
  task automatic chk(input string name, input data_t act, input data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic rst, input logic we, input sel_t dst, input data_t din, input sel_t s1, input sel_t s2);
    @(posedge Clk);
    #1;
    Reset = rst;
    bus.REG_WE = we;
    bus.REG_Dst = dst;
    bus.DIn = din;
    bus.REG_Src1 = s1;
    bus.REG_Src2 = s2;
  endtask
  function automatic data_t rd(input sel_t s);
    return (Z && s == 0) ? '0 : model[s];
  endfunction
  initial begin
    Reset = 1'b1;
    bus.REG_WE = 1'b1;
    bus.REG_Dst = '0;
    bus.DIn = '0;
    bus.REG_Src1 = '0;
    bus.REG_Src2 = '0;
    tbl[0] = '{1, 1, 0, 16'h0000, 0, 7, 16'h0000, 16'h0000};
    tbl[1] = '{0, 0, 0, 16'h00A0, 0, 0, Z ? 16'h0 : 16'h00A0, Z ? 16'h0 : 16'h00A0};
    tbl[2] = '{0, 0, 1, 16'h000A, 1, 0, 16'h000A, Z ? 16'h0 : 16'h00A0};
    tbl[3] = '{0, 1, 1, 16'hFFFF, 0, 1, Z ? 16'h0 : 16'h00A0, 16'h000A};
    tbl[4] = '{0, 1, 1, 16'hFFFF, 1, 1, 16'h000A, 16'h000A};
    tbl[5] = '{0, 1, 1, 16'hFFFF, 1, 1, 16'h000A, 16'h000A};
    tbl[6] = '{0, 0, 2, 16'h1234, 2, 1, 16'h1234, 16'h000A};
    tbl[7] = '{1, 0, 2, 16'h5678, 2, 1, 16'h0000, 16'h0000};
    tbl[8] = '{0, 0, 0, 16'h5555, 0, 2, Z ? 16'h0 : 16'h5555, 16'h0000};
    for (int k = 0; k < 9; k++) begin
      drive(tbl[k].rst, tbl[k].we, tbl[k].dst, tbl[k].din, tbl[k].s1, tbl[k].s2);
      @(negedge Clk);
      #2;
      chk($sformatf("vec%0d_src1", k), bus.SRC1, tbl[k].e1);
      chk($sformatf("vec%0d_src2", k), bus.SRC2, tbl[k].e2);
      if (k == 0 || k == 7)
        for (int s = 0; s < NUM_REGS; s++) begin
          bus.REG_Src1 = sel_t'(s);
          bus.REG_Src2 = sel_t'(NUM_REGS - 1 - s);
          #1;
          chk($sformatf("rst%0d_sel%0d_src1", k, s), bus.SRC1, 16'h0000);
          chk($sformatf("rst%0d_sel%0d_src2", k, s), bus.SRC2, 16'h0000);
        end
    end
    drive(0, 0, 3, 16'hBEEF, 3, 3);
    @(negedge Clk);
    #2;
    chk("rdw_first", bus.SRC1, 16'hBEEF);
    drive(0, 0, 3, 16'hCAFE, 3, 2);
    #1;
    chk("rdw_old_value", bus.SRC1, 16'hBEEF);
    @(negedge Clk);
    #2;
    chk("rdw_new_value", bus.SRC1, 16'hCAFE);
    bus.REG_WE = 1'b1;
    #3;
    bus.REG_Src2 = 3'd3;
    #1;
    chk("midcycle_sel_src2", bus.SRC2, 16'hCAFE);
    drive(1, 1, 0, 0, 0, 0);
    @(negedge Clk);
    for (int r = 0; r < NUM_REGS; r++) model[r] = '0;
    for (int n = 0; n < 400; n++) begin
      logic rst, we;
      sel_t dst, s1, s2;
      data_t din;
      rst = ($urandom_range(0, 19) == 0);
      we = $urandom_range(0, 2) == 0;
      dst = sel_t'($urandom);
      din = data_t'($urandom);
      s1 = sel_t'($urandom);
      s2 = ($urandom_range(0, 3) == 0) ? dst : sel_t'($urandom);
      drive(rst, we, dst, din, s1, s2);
      #1;
      chk($sformatf("rnd%0d_pre_src1", n), bus.SRC1, rd(s1));
      @(negedge Clk);
      if (rst) for (int r = 0; r < NUM_REGS; r++) model[r] = '0;
      else if (!we) model[dst] = din;
      #2;
      chk($sformatf("rnd%0d_src1", n), bus.SRC1, rd(s1));
      chk($sformatf("rnd%0d_src2", n), bus.SRC2, rd(s2));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
